// File: rtl/sram_bridge.sv
// sram_bridge: blocking bridge from the memory pipeline stage to an
// SRAM-like two-phase handshake bus. One bus transaction per request;
// the pipeline is held with a combinational stall until the transaction
// finishes, and the read word is returned through a register.
//
// Bus handshake: bus_req and all bus_* fields are registered and stay
// constant while bus_req=1; the address phase completes in the cycle
// bus_addr_ok is sampled high, after which bus_req drops. The data phase
// completes in the cycle bus_data_ok is sampled high (never earlier than
// its bus_addr_ok); bus_rdata is only meaningful in that cycle.
// With POST_WRITE=1 a write releases the pipeline right after bus_addr_ok
// and its bus_data_ok is absorbed later through the pend_w flag; no new
// request is issued while pend_w is set.
module sram_bridge #(
  parameter int POST_WRITE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_data,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic POSTED = (POST_WRITE != 0);

  state_t state;
  state_t state_nxt;
  logic   pend_w;
  logic   issue;
  logic   rd_cap;
  logic   post_set;
  logic   post_clr;

  // Byte offset bits are dropped; the bus is word addressed.
  logic   unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, req_addr[1:0]};

  // Next-state decode and per-cycle handshake events
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    rd_cap    = 1'b0;
    post_set  = 1'b0;
    case (state)
      IDLE: begin
        // A posted write still in flight blocks the next issue.
        if (req_en && !pend_w) begin
          issue     = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            rd_cap    = !bus_wr;
            state_nxt = DONE;
          end else if (bus_wr && POSTED) begin
            post_set  = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (bus_data_ok) begin
          rd_cap    = !bus_wr;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // The request still on req_en here is the one just served.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Late data acknowledge of a posted write, seen outside a transaction
  assign post_clr = pend_w && bus_data_ok && ((state == IDLE) || (state == DONE));

  assign stall = ((state == IDLE) && req_en) || (state == ADDR) || (state == DATA);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Posted-write pending flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          pend_w <= 1'b0;
    else if (post_set) pend_w <= 1'b1;
    else if (post_clr) pend_w <= 1'b0;
  end

  // Bus request and transaction fields, latched once per issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wstrb <= 4'h0;
      bus_wdata <= 32'h0;
    end else if (issue) begin
      bus_req   <= 1'b1;
      bus_wr    <= req_wr;
      bus_addr  <= {req_addr[31:2], 2'b00};
      bus_wstrb <= req_wr ? req_mask : 4'h0;
      bus_wdata <= req_data;
    end else if ((state == ADDR) && bus_addr_ok) begin
      bus_req   <= 1'b0;
    end
  end

  // Read word register; only a read capture changes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        rdata <= 32'h0;
    else if (rd_cap) rdata <= bus_rdata;
  end

endmodule

// File: tb/tb_sram_bridge.sv
// Self-checking bench for sram_bridge: one blocking instance and one
// posted-write instance, a bus slave with its own word memory, and a
// read scoreboard fed from a word-memory reference model.
module tb_sram_bridge;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- per-instance signals (0 = blocking, 1 = posted) ----------------
  logic        req_en    [2];
  logic        req_wr    [2];
  logic [31:0] req_addr  [2];
  logic [3:0]  req_mask  [2];
  logic [31:0] req_data  [2];
  logic        stall     [2];
  logic [31:0] rdata     [2];
  logic        bus_req   [2];
  logic        bus_wr    [2];
  logic [31:0] bus_addr  [2];
  logic [3:0]  bus_wstrb [2];
  logic [31:0] bus_wdata [2];
  logic        addr_ok   [2];
  logic        data_ok   [2];
  logic [31:0] bus_rdata [2];

  sram_bridge #(.POST_WRITE(0)) u_blk (
    .clk(clk), .rst(rst_n),
    .req_en(req_en[0]), .req_wr(req_wr[0]), .req_addr(req_addr[0]),
    .req_mask(req_mask[0]), .req_data(req_data[0]),
    .stall(stall[0]), .rdata(rdata[0]),
    .bus_req(bus_req[0]), .bus_wr(bus_wr[0]), .bus_addr(bus_addr[0]),
    .bus_wstrb(bus_wstrb[0]), .bus_wdata(bus_wdata[0]),
    .bus_addr_ok(addr_ok[0]), .bus_data_ok(data_ok[0]), .bus_rdata(bus_rdata[0])
  );

  sram_bridge #(.POST_WRITE(1)) u_post (
    .clk(clk), .rst(rst_n),
    .req_en(req_en[1]), .req_wr(req_wr[1]), .req_addr(req_addr[1]),
    .req_mask(req_mask[1]), .req_data(req_data[1]),
    .stall(stall[1]), .rdata(rdata[1]),
    .bus_req(bus_req[1]), .bus_wr(bus_wr[1]), .bus_addr(bus_addr[1]),
    .bus_wstrb(bus_wstrb[1]), .bus_wdata(bus_wdata[1]),
    .bus_addr_ok(addr_ok[1]), .bus_data_ok(data_ok[1]), .bus_rdata(bus_rdata[1])
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- memories: reference model and bus slave ----------------
  logic [31:0] mmem [bit [30:0]];
  logic [31:0] smem [bit [30:0]];

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return {w[14:0], w[29:13]} ^ 32'hA5C3_5A3C;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] m, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic bit [30:0] key(input int u, input logic [31:0] a);
    return {u[0], a[31:2]};
  endfunction

  function automatic logic [31:0] m_rd(input int u, input logic [31:0] a);
    return mmem.exists(key(u, a)) ? mmem[key(u, a)] : init_word(a[31:2]);
  endfunction

  function automatic void m_wr(input int u, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    mmem[key(u, a)] = merge(m_rd(u, a), m, d);
  endfunction

  function automatic logic [31:0] s_rd(input int u, input logic [31:0] a);
    return smem.exists(key(u, a)) ? smem[key(u, a)] : init_word(a[31:2]);
  endfunction

  function automatic void s_wr(input int u, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    smem[key(u, a)] = merge(s_rd(u, a), m, d);
  endfunction

  // ---------------- bus slave + scoreboard monitor ----------------
  bit          in_addr [2];
  bit          dpend   [2];
  int          acnt    [2];
  int          dcnt    [2];
  int          aw_fix  [2];   // -1 selects a random wait
  int          dw_fix  [2];
  int          nreq    [2];
  int          n_iss   [2];
  logic        hwr     [2];
  logic [31:0] haddr   [2];
  logic [3:0]  hwstrb  [2];
  logic [31:0] hwdata  [2];
  logic [31:0] last_rd [2];
  bit          recheck [2];

  task automatic fire(input int u);
    data_ok[u] = 1'b1;
    dpend[u]   = 1'b0;
    if (!hwr[u]) bus_rdata[u] = s_rd(u, haddr[u]);
    else         s_wr(u, haddr[u], hwstrb[u], hwdata[u]);
  endtask

  task automatic slave_step(input int u);
    addr_ok[u]   = 1'b0;
    data_ok[u]   = 1'b0;
    bus_rdata[u] = $urandom;
    if (!rst_n) begin
      in_addr[u] = 1'b0;
      dpend[u]   = 1'b0;
    end else begin
      if (dpend[u]) begin
        dcnt[u]--;
        if (dcnt[u] == 0) fire(u);
      end
      if (bus_req[u]) begin
        if (!in_addr[u]) begin
          in_addr[u] = 1'b1;
          nreq[u]++;
          hwr[u] = bus_wr[u]; haddr[u] = bus_addr[u];
          hwstrb[u] = bus_wstrb[u]; hwdata[u] = bus_wdata[u];
          acnt[u] = (aw_fix[u] >= 0) ? aw_fix[u] : int'($urandom_range(0, 5));
          chk("issue_wr", 32'(bus_wr[u]), 32'(req_wr[u]));
          chk("issue_addr", bus_addr[u], {req_addr[u][31:2], 2'b00});
          chk("issue_wstrb", 32'(bus_wstrb[u]), req_wr[u] ? 32'(req_mask[u]) : 32'h0);
          if (req_wr[u]) chk("issue_wdata", bus_wdata[u], req_data[u]);
        end else begin
          chk("hold_wr", 32'(bus_wr[u]), 32'(hwr[u]));
          chk("hold_addr", bus_addr[u], haddr[u]);
          chk("hold_wstrb", 32'(bus_wstrb[u]), 32'(hwstrb[u]));
          chk("hold_wdata", bus_wdata[u], hwdata[u]);
        end
        if (acnt[u] == 0) begin
          addr_ok[u] = 1'b1;
          in_addr[u] = 1'b0;
          dcnt[u] = (dw_fix[u] >= 0) ? dw_fix[u] : int'($urandom_range(0, 5));
          if (dcnt[u] == 0) fire(u);
          else              dpend[u] = 1'b1;
        end else begin
          acnt[u]--;
        end
      end
    end
  endtask

  task automatic mon_step(input int u);
    logic [31:0] e;
    if (!rst_n) begin
      last_rd[u] = 32'h0;
      recheck[u] = 1'b0;
    end else begin
      if (recheck[u]) begin
        chk("rdata_next_cycle", rdata[u], last_rd[u]);
        recheck[u] = 1'b0;
      end
      if (req_en[u] && !stall[u]) begin
        if (!req_wr[u]) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rdata_unexpected: read released with empty queue, rdata %h", rdata[u]);
          end else begin
            e = exp_q.pop_front();
            chk("rdata", rdata[u], e);
            last_rd[u] = e;
            recheck[u] = 1'b1;
          end
        end else begin
          chk("rdata_hold_write", rdata[u], last_rd[u]);
        end
      end
    end
  endtask

  // Slave answers just after the rising edge; monitor samples on the falling edge
  always begin
    @(posedge clk);
    #1;
    slave_step(0);
    slave_step(1);
    @(negedge clk);
    mon_step(0);
    mon_step(1);
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the edge that ends the release cycle.
  task automatic access(input int u, input bit wr, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] d, output int sc);
    req_en[u] = 1'b1; req_wr[u] = wr; req_addr[u] = a; req_mask[u] = m; req_data[u] = d;
    n_iss[u]++;
    if (wr) m_wr(u, a, m, d);
    else    exp_q.push_back(m_rd(u, a));
    sc = 0;
    forever begin
      @(negedge clk);
      if (!stall[u]) break;
      sc++;
      if (sc > 300) begin
        n_checks++;
        n_errors++;
        $display("FAIL access_timeout: unit %0d stall still %0d after %0d cycles", u, stall[u], sc);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int u, input int n);
    if (n > 0) begin
      req_en[u] = 1'b0;
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int sc;
    int n0;
    bit wr;
    logic [31:0] a;

    for (int u = 0; u < 2; u++) begin
      req_en[u] = 1'b0; req_wr[u] = 1'b0; req_addr[u] = 32'h0;
      req_mask[u] = 4'h0; req_data[u] = 32'h0;
      addr_ok[u] = 1'b0; data_ok[u] = 1'b0; bus_rdata[u] = 32'h0;
      aw_fix[u] = -1; dw_fix[u] = -1; nreq[u] = 0; n_iss[u] = 0;
      last_rd[u] = 32'h0; recheck[u] = 1'b0; in_addr[u] = 1'b0; dpend[u] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("reset_stall", 32'(stall[u]), 32'h0);
      chk("reset_bus_req", 32'(bus_req[u]), 32'h0);
      chk("reset_bus_wr", 32'(bus_wr[u]), 32'h0);
      chk("reset_rdata", rdata[u], 32'h0);
      chk("reset_bus_addr", bus_addr[u], 32'h0);
      chk("reset_bus_wstrb", 32'(bus_wstrb[u]), 32'h0);
      chk("reset_bus_wdata", bus_wdata[u], 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait read: stall 1,1,0
    mmem[key(0, 32'h1000_0004)] = 32'hA1B2_C3D4;
    smem[key(0, 32'h1000_0004)] = 32'hA1B2_C3D4;
    aw_fix[0] = 0; dw_fix[0] = 0;
    access(0, 1'b0, 32'h1000_0006, 4'hF, 32'hFFFF_FFFF, sc);
    chk("rd0_stall_cycles", sc, 2);
    chk("rd0_bus_addr", haddr[0], 32'h1000_0004);
    chk("rd0_bus_wstrb", 32'(hwstrb[0]), 32'h0);
    idle(0, 2);

    // Write with 2 address waits and 3 data waits
    n0 = nreq[0];
    aw_fix[0] = 2; dw_fix[0] = 3;
    access(0, 1'b1, 32'h1000_0008, 4'b0100, 32'h00EF_0000, sc);
    chk("wr_stall_cycles", sc, 7);
    chk("wr_one_request", nreq[0] - n0, 1);
    chk("wr_bus_wstrb", 32'(hwstrb[0]), 32'h4);
    chk("wr_bus_wdata", hwdata[0], 32'h00EF_0000);
    idle(0, 1);
    chk("wr_rdata_kept", rdata[0], 32'hA1B2_C3D4);

    // Re-issue guard: req_en held high across three back-to-back reads
    n0 = nreq[0];
    aw_fix[0] = 0; dw_fix[0] = 0;
    for (int i = 0; i < 3; i++) begin
      access(0, 1'b0, 32'h1000_0008 + 32'(i * 4), 4'h0, 32'h0, sc);
      chk("b2b_stall_cycles", sc, 2);
    end
    idle(0, 2);
    chk("b2b_requests", nreq[0] - n0, 3);

    // Posted write: data_ok 4 cycles after addr_ok, then an immediate read
    aw_fix[1] = 0; dw_fix[1] = 4;
    access(1, 1'b1, 32'h3000_0010, 4'b1111, 32'h1234_5678, sc);
    chk("post_wr_release", sc, 2);
    dw_fix[1] = 0;
    access(1, 1'b0, 32'h3000_0010, 4'h0, 32'h0, sc);
    chk("post_rd_stall_cycles", sc, 5);
    idle(1, 2);

    // Asynchronous reset in the middle of the address phase
    aw_fix[0] = 20; dw_fix[0] = 0;
    req_en[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0] = 32'h1000_0004;
    n_iss[0]++;
    @(posedge clk);
    #3;
    chk("pre_reset_bus_req", 32'(bus_req[0]), 32'h1);
    rst_n = 1'b0;
    req_en[0] = 1'b0;
    #1;
    chk("mid_reset_bus_req", 32'(bus_req[0]), 32'h0);
    chk("mid_reset_rdata", rdata[0], 32'h0);
    chk("mid_reset_stall", 32'(stall[0]), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    aw_fix[0] = 0; dw_fix[0] = 1;
    access(0, 1'b0, 32'h1000_0004, 4'h0, 32'h0, sc);
    chk("post_reset_stall_cycles", sc, 3);
    idle(0, 1);
    chk("post_reset_rdata", rdata[0], 32'hA1B2_C3D4);

    // Random soak: 500 accesses on each instance, random waits 0-5
    for (int u = 0; u < 2; u++) begin
      aw_fix[u] = -1; dw_fix[u] = -1;
      for (int i = 0; i < 500; i++) begin
        wr = 1'($urandom_range(0, 1));
        a = 32'h2000_0000 + 32'($urandom_range(0, 63));
        access(u, wr, a, 4'($urandom_range(0, 15)), $urandom, sc);
        idle(u, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2)) : 0);
      end
      idle(u, 12);
    end

    chk("exp_queue_empty", 32'(exp_q.size()), 32'h0);
    chk("blk_request_count", nreq[0], n_iss[0]);
    chk("post_request_count", nreq[1], n_iss[1]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
